// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: sequencer state encoding and default operand width.
package arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DIV,
    FIX,
    DONE
  } arith_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes, MSB first.
module div_step
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH:0]   divisor_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // Partial remainder stays below |divisor| (or is the dividend itself for /0), so WIDTH bits hold it.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= divisor_mag);
    rem_out = q_bit ? WIDTH'(shifted - divisor_mag) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_module.sv
// Sequential signed restoring divider on the start_sig/done_sig handshake, fixed WIDTH+2 latency.
module divider_module
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_sig,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_sig,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  arith_state_t state, next_state;

  logic             armed;
  logic [WIDTH-1:0] a_op, b_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH:0]   dvs_mag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q_acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH:0]   b_ext;

  always_comb b_ext = {b_op[WIDTH-1], b_op};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem),
    .bit_in      (dvd_sh[WIDTH-1]),
    .divisor_mag (dvs_mag),
    .rem_out     (step_rem),
    .q_bit       (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start_sig && armed) next_state = INIT;
      INIT:    next_state = DIV;
      DIV:     if (cnt == CNT_LAST) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb done_sig = (state == DONE);

  // A low start_sig re-arms even in DONE, so a one-cycle drop right after done_sig suffices.
  always_ff @(posedge clk) begin
    if (rst)                armed <= 1'b1;
    else if (!start_sig)    armed <= 1'b1;
    else if (state == DONE) armed <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_op      <= '0;
      b_op      <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      dvd_sh    <= '0;
      dvs_mag   <= '0;
      rem       <= '0;
      q_acc     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_sig && armed) begin
            a_op <= dividend;
            b_op <= divisor;
          end
        end
        INIT: begin
          a_neg    <= a_op[WIDTH-1];
          b_neg    <= b_op[WIDTH-1];
          dvd_sh   <= a_op[WIDTH-1] ? -a_op : a_op;
          dvs_mag  <= b_ext[WIDTH] ? -b_ext : b_ext;
          rem      <= '0;
          q_acc    <= '0;
          cnt      <= '0;
          div_zero <= 1'b0;
        end
        DIV: begin
          rem    <= step_rem;
          dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
          q_acc  <= {q_acc[WIDTH-2:0], step_q};
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          if (b_op == '0) begin
            quotient  <= '1;
            remainder <= a_op;
            div_zero  <= 1'b1;
          end else begin
            // -2^(WIDTH-1) / -1 wraps naturally: magnitude 2^(WIDTH-1) reads back as itself.
            quotient  <= (a_neg ^ b_neg) ? -q_acc : q_acc;
            remainder <= a_neg ? -rem : rem;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_module.sv
// Directed and random initiator bench for divider_module with a result scoreboard.
module tb_divider_module;
  import arith_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_sig;
  logic [W-1:0] dividend, divisor;
  logic         done_sig;
  logic [W-1:0] quotient, remainder;
  logic         div_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t        sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  divider_module #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_sig (start_sig),
    .dividend  (dividend),
    .divisor   (divisor),
    .done_sig  (done_sig),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa, sd;
    sa = $signed(a);
    sd = $signed(b);
    if (sd == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (sa == -128 && sd == -1) begin
      e.q = 8'h80; e.r = '0; e.dz = 1'b0;
    end else begin
      e.q = 8'(sa / sd); e.r = 8'(sa % sd); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called #1 after an edge with the DUT idle and armed; hold = extra cycles start stays high after done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input string tag);
    exp_t e;
    int   cyc;
    int   extra;
    bit   seen;
    dividend  = a;
    divisor   = b;
    start_sig = 1'b1;
    sb.push_back(model(a, b));
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done_sig) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      check({tag, "_latency"}, 32'(cyc - 1), 32'(W + 2));
      check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
      check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      check({tag, "_div_zero"}, 32'(div_zero), 32'(e.dz));
    end
    extra = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (done_sig) extra++;
    end
    if (hold > 0) check({tag, "_single_pulse"}, 32'(extra), 32'd0);
    start_sig = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done_sig), 32'd0);
  endtask

  initial begin
    int extra;
    logic [W-1:0] ra, rb;
    rst       = 1'b1;
    start_sig = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done_sig), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'd20, 8'd2, 0, "t1_20_2");
    run_op(8'd2, 8'd10, 0, "t2_2_10");
    run_op(8'd11, 8'hFB, 0, "t2_11_m5");
    run_op(8'hC9, 8'hF5, 0, "t3_m55_m11");
    run_op(8'hF9, 8'd2, 0, "t3_m7_2");
    run_op(8'd9, 8'd0, 0, "t4_div0");
    run_op(8'h80, 8'hFF, 0, "t4_ovf");
    run_op(8'd7, 8'd3, 15, "t5_held");
    run_op(8'd100, 8'd7, 0, "t5_rearm");

    // Abort during the fourth DIV cycle.
    dividend  = 8'd100;
    divisor   = 8'd3;
    start_sig = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_done", 32'(done_sig), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_div_zero", 32'(div_zero), 32'd0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    rst       = 1'b0;
    start_sig = 1'b0;
    extra     = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_sig) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
    run_op(8'h9C, 8'd9, 0, "t6_after_abort");

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(ra, rb, 0, $sformatf("rand%0d", i));
    end
    run_op(8'h80, 8'd1, 0, "edge_min_1");
    run_op(8'h7F, 8'h80, 0, "edge_max_min");
    run_op(8'h80, 8'h80, 0, "edge_min_min");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
